bnn_core: RTL and testbench

//   Binary-activation 2-2-1 feed-forward neural network evaluator (block name BNN).
//   Two 1-bit inputs drive two hidden step-neurons, which drive one output step-neuron.

---
 rtl/bnn_core.sv | 106 ++++++++++
 tb/tb_bnn_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bnn_core.sv
// rtl/bnn_core.sv - two-stage 2-2-1 binary-activation neural network evaluator
//
// Purpose
//   Two 1-bit input features drive two hidden step-neurons. The hidden
//   neurons drive one output step-neuron. Weights and biases are run-time
//   inputs, and the caller holds them static.
//
//   With the table wt = {20,20,-20,-20,20,20} (wt[0] first) and
//   b = {-30,10,-10} (b[0] first), the block computes x0 XNOR x1:
//     h0 = AND
//     h1 = NOR
//     out = OR(h0, h1)
//
// Ports
//   Clk    in   1                   rising-edge clock
//   Reset  in   1                   synchronous active-high reset
//   x0     in   1                   input feature 0
//   x1     in   1                   input feature 1
//   wt     in   6 x WIDTH signed    weights; index map below
//   b      in   3 x WIDTH signed    biases; index map below
//   out    out  1                   registered network output
//
// Index map
//   h0  = step(wt[0]*x0 + wt[1]*x1 + b[0])
//   h1  = step(wt[2]*x0 + wt[3]*x1 + b[1])
//   out = step(wt[4]*h0 + wt[5]*h1 + b[2])
//   step(s) = (s >= 0)
//
// Timing
//   Inputs sampled at edge N reach out after edge N+1.
//   A new input can be accepted every cycle.

module bnn_core #(
    parameter int WIDTH = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    x0,
    input  logic                    x1,
    input  logic signed [WIDTH-1:0] wt [6],
    input  logic signed [WIDTH-1:0] b  [3],
    output logic                    out
);

    // Three WIDTH-bit signed operands need at most two extra bits.
    // Sums at this width can never wrap.
    localparam int SW = WIDTH + 2;

    // A 1-bit activation times a weight is a select, not a multiply.
    function automatic logic signed [SW-1:0] gate_term(
        input logic                    act,
        input logic signed [WIDTH-1:0] w
    );
        logic signed [SW-1:0] ext;
        ext = {{2{w[WIDTH-1]}}, w};
        return act ? ext : '0;
    endfunction

    function automatic logic signed [SW-1:0] sext(
        input logic signed [WIDTH-1:0] v
    );
        return {{2{v[WIDTH-1]}}, v};
    endfunction

    // The sign bit decides the step; an exact zero counts as firing.
    function automatic logic step(input logic signed [SW-1:0] s);
        return ~s[SW-1];
    endfunction

    logic h0_q, h0_d;
    logic h1_q, h1_d;
    logic out_q, out_d;

    logic signed [SW-1:0] sum_h0;
    logic signed [SW-1:0] sum_h1;
    logic signed [SW-1:0] sum_out;

    // Stage 1: hidden-layer sums from the live inputs
    always_comb begin
        sum_h0 = gate_term(x0, wt[0]) + gate_term(x1, wt[1]) + sext(b[0]);
        sum_h1 = gate_term(x0, wt[2]) + gate_term(x1, wt[3]) + sext(b[1]);
        h0_d   = step(sum_h0);
        h1_d   = step(sum_h1);
    end

    // Stage 2: output sum from the registered hidden activations
    always_comb begin
        sum_out = gate_term(h0_q, wt[4]) + gate_term(h1_q, wt[5]) + sext(b[2]);
        out_d   = step(sum_out);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h0_q  <= 1'b0;
            h1_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            h0_q  <= h0_d;
            h1_q  <= h1_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_bnn_core.sv
// tb/tb_bnn_core.sv - directed table-driven bench for bnn_core

module tb_bnn_core;

    localparam int W = 16;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                x0;
    logic                x1;
    logic signed [W-1:0] wt [6];
    logic signed [W-1:0] b  [3];
    logic                out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    bnn_core #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .x0    (x0),
        .x1    (x1),
        .wt    (wt),
        .b     (b),
        .out   (out)
    );

    typedef struct {
        string name;
        int    tbl;
        logic  x0;
        logic  x1;
        logic  exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // 0 default XNOR, 1 XOR, 2 all max, 3 all min, 4 default hidden with zeroed output neuron
    task automatic load_table(input int t);
        case (t)
            1: begin
                for (int i = 0; i < 5; i++) wt[i] = 16'sd20;
                wt[5] = -16'sd20;
                b[0] = -16'sd10;
                b[1] = -16'sd30;
                b[2] = -16'sd10;
            end
            2: begin
                for (int i = 0; i < 6; i++) wt[i] = 16'sh7fff;
                for (int i = 0; i < 3; i++) b[i] = 16'sh7fff;
            end
            3: begin
                for (int i = 0; i < 6; i++) wt[i] = 16'sh8000;
                for (int i = 0; i < 3; i++) b[i] = 16'sh8000;
            end
            default: begin
                wt[0] = 16'sd20;
                wt[1] = 16'sd20;
                wt[2] = -16'sd20;
                wt[3] = -16'sd20;
                wt[4] = 16'sd20;
                wt[5] = 16'sd20;
                b[0] = -16'sd30;
                b[1] = 16'sd10;
                b[2] = -16'sd10;
                if (t == 4) begin
                    wt[4] = 16'sd0;
                    wt[5] = 16'sd0;
                    b[2]  = 16'sd0;
                end
            end
        endcase
    endtask

    initial begin
        logic [1:0] seq [10];
        logic [1:0] prev;

        vecs[0]  = '{"def_00",  0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"def_01",  0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{"def_10",  0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"def_11",  0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{"xor_00",  1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"xor_01",  1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{"xor_10",  1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{"xor_11",  1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"max_11",  2, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{"max_00",  2, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{"min_11",  3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{"min_00",  3, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"zero_00", 4, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{"zero_11", 4, 1'b1, 1'b1, 1'b1};

        // Reset held for two edges
        load_table(0);
        Reset = 1'b1;
        x0 = 1'b1;
        x1 = 1'b0;
        tick();
        tick();
        check("rst_out", out, 1'b0);
        check("rst_h0", dut.h0_q, 1'b0);
        check("rst_h1", dut.h1_q, 1'b0);

        // Release with x=(0,0); the first edge still sees the reset hidden layer
        Reset = 1'b0;
        x0 = 1'b0;
        x1 = 1'b0;
        tick();
        check("rel_edge1", out, 1'b0);
        tick();
        check("rel_edge2", out, 1'b1);

        // Table-driven vectors, each held for two edges
        foreach (vecs[i]) begin
            load_table(vecs[i].tbl);
            x0 = vecs[i].x0;
            x1 = vecs[i].x1;
            tick();
            tick();
            check(vecs[i].name, out, vecs[i].exp);
        end

        // Back-to-back stream with the default table
        load_table(0);
        seq = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3};
        prev = 2'd0;
        for (int k = 0; k < 10; k++) begin
            x1 = seq[k][1];
            x0 = seq[k][0];
            tick();
            if (k > 0) check($sformatf("stream_%0d", k - 1), out, ~(prev[1] ^ prev[0]));
            prev = seq[k];
        end
        tick();
        check("stream_9", out, ~(prev[1] ^ prev[0]));

        // One-edge reset right after an input change
        x0 = 1'b1;
        x1 = 1'b1;
        tick();
        tick();
        check("pre_rst", out, 1'b1);
        x0 = 1'b0;
        x1 = 1'b1;
        Reset = 1'b1;
        tick();
        check("mid_rst_out", out, 1'b0);
        check("mid_rst_h0", dut.h0_q, 1'b0);
        Reset = 1'b0;
        x0 = 1'b0;
        x1 = 1'b0;
        tick();
        check("post_rst_e1", out, 1'b0);
        tick();
        check("post_rst_e2", out, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
